// File: rtl/dmem_if.sv
// Data-memory port between the CPU load/store unit and the data memory.
// master: CPU side, drives the request; slave: memory side, returns status.
//   req    request valid            busy   request in flight
//   we     1 = store, 0 = load      ready  one-cycle completion pulse
//   addr   byte address             rdata  load data (valid with ready)
//   wdata  store data               err    access rejected (with ready)
//   be     store byte enables
interface dmem_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   logic              req;
   logic              we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [BE_W-1:0]   be;
   logic              busy;
   logic              ready;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (output req, we, addr, wdata, be,
                   input  busy, ready, rdata, err);
   modport slave  (input  req, we, addr, wdata, be,
                   output busy, ready, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed number of wait states, used in place of
// a zero-latency data memory so the CPU stall path sees real back-pressure.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous reset, active-high (array contents are kept)
//   bus  dmem_if.slave: req/we/addr/wdata/be in, busy/ready/rdata/err out
// Parameters:
//   ADDR_W       word-address bits, array depth 2**ADDR_W words
//   WAIT_CYCLES  wait states between acceptance and completion (0..15)
module dmem_responder #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   // Counter is only 4 bits wide, so larger wait counts cannot be represented.
   if (WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // Request fields captured at acceptance.
   logic               r_we;
   logic [DATA_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [BE_W-1:0]    r_be;

   // Registered outputs and their next values.
   logic               r_busy;
   logic               r_ready;
   logic               r_err;
   logic [DATA_W-1:0]  r_rdata;
   logic               w_busy_nxt;
   logic               w_ready_nxt;
   logic               w_err_nxt;
   logic [DATA_W-1:0]  w_rdata_nxt;

   logic               w_accept;
   logic               w_commit;
   logic               w_mem_we;

   // Access being completed: straight from the bus when committing out of
   // IDLE (WAIT_CYCLES=0), otherwise the captured copy.
   logic               w_acc_we;
   logic [DATA_W-1:0]  w_acc_addr;
   logic [DATA_W-1:0]  w_acc_wdata;
   logic [BE_W-1:0]    w_acc_be;
   logic               w_misaligned;
   logic               w_out_of_range;
   logic               w_acc_err;
   logic [ADDR_W-1:0]  w_word_idx;

   logic [DATA_W-1:0]  r_mem [DEPTH];

   assign w_accept    = (r_state == S_IDLE) && bus.req;

   assign w_acc_we    = (r_state == S_IDLE) ? bus.we    : r_we;
   assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
   assign w_acc_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;
   assign w_acc_be    = (r_state == S_IDLE) ? bus.be    : r_be;

   // Address checks: word alignment and upper bits beyond the array.
   assign w_misaligned   = (w_acc_addr[1:0] != 2'b00);
   assign w_out_of_range = ((w_acc_addr >> (ADDR_W + 2)) != '0);
   assign w_acc_err      = w_misaligned || w_out_of_range;
   assign w_word_idx     = w_acc_addr[ADDR_W+1:2];

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_ready_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = '0;
      w_mem_we    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.req) begin
               w_cnt_nxt = CNT_W'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = S_DONE;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = S_DONE;
               w_commit    = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_ready_nxt = w_commit;
      w_err_nxt   = w_commit && w_acc_err;
      if (w_commit && !w_acc_we && !w_acc_err) begin
         w_rdata_nxt = r_mem[w_word_idx];
      end
      w_mem_we    = w_commit && w_acc_we && !w_acc_err;
   end

   // State, counter, captured request and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_be    <= bus.be;
         end
         r_busy  <= w_busy_nxt;
         r_ready <= w_ready_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   // Byte-masked store; reset suppresses a commit so an aborted store never lands.
   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) begin
         for (int i = 0; i < int'(BE_W); i++) begin
            if (w_acc_be[i]) begin
               r_mem[w_word_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.busy  = r_busy;
   assign bus.ready = r_ready;
   assign bus.err   = r_err;
   assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance, each with its own dmem_if; expected responses come from a word
// model and are queued at issue time, then popped when ready is seen.
module tb_dmem_responder;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned TMO    = 40;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rst0;

   always #5 clk = ~clk;

   dmem_if bus  ();
   dmem_if bus0 ();

   dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (bus0.slave)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb [$];
   logic [31:0] mdl  [int unsigned];
   logic [31:0] mdl0 [int unsigned];

   function automatic logic rdy(input bit s0);
      return s0 ? bus0.ready : bus.ready;
   endfunction

   function automatic logic bsy(input bit s0);
      return s0 ? bus0.busy : bus.busy;
   endfunction

   // Wait for idle, present one request for one edge, queue its expected result.
   task automatic issue(input bit s0, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      exp_t        e;
      logic [31:0] w;
      int unsigned idx;
      int          k;
      k = 0;
      while (bsy(s0) && k < int'(TMO)) begin
         @(posedge clk); #1;
         k++;
      end
      e.err   = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'h0);
      e.rdata = 32'h0;
      idx     = int'(addr[ADDR_W+1:2]);
      if (!e.err) begin
         if (s0) w = mdl0.exists(idx) ? mdl0[idx] : 32'h0;
         else    w = mdl.exists(idx)  ? mdl[idx]  : 32'h0;
         if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
            if (s0) mdl0[idx] = w; else mdl[idx] = w;
         end else begin
            e.rdata = w;
         end
      end
      sb.push_back(e);
      if (s0) begin
         bus0.req = 1'b1; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata; bus0.be = be;
      end else begin
         bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.be = be;
      end
      @(posedge clk); #1;
      if (s0) bus0.req = 1'b0; else bus.req = 1'b0;
   endtask

   // Issue, then wait for ready; lat counts edges from the accepting edge (=1).
   task automatic op(input bit s0, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output int lat, output logic g_err, output logic [31:0] g_rd,
                     output exp_t e);
      issue(s0, we, addr, wdata, be);
      lat = 1;
      while (!rdy(s0) && lat < int'(TMO)) begin
         @(posedge clk); #1;
         lat++;
      end
      if (rdy(s0)) begin
         g_err = s0 ? bus0.err   : bus.err;
         g_rd  = s0 ? bus0.rdata : bus.rdata;
      end else begin
         g_err = 1'bx;
         g_rd  = 'x;
         lat   = 999;
      end
      if (sb.size() > 0) e = sb.pop_front();
      else begin e.err = 1'bx; e.rdata = 'x; end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (bus.busy  !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_chk++; if (bus.ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
      n_chk++; if (bus.err   !== 1'b0)  begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
      n_chk++; if ({bus0.busy, bus0.ready, bus0.err} !== 3'b000 || bus0.rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset0_outs got=%b%b%b/%h exp=000/0", bus0.busy, bus0.ready, bus0.err, bus0.rdata);
      end
      rst = 1'b0; rst0 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      int lat; logic ge; logic [31:0] gr; exp_t e;
      op(1'b0, 1'b1, 32'h10, 32'h11111111, 4'hF, lat, ge, gr, e);
      n_chk++; if (ge !== e.err) begin n_fail++; $display("FAIL abort_prestore_err got=%b exp=%b", ge, e.err); end
      @(posedge clk); #1;
      // Store that gets aborted: not pushed, model untouched.
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF; bus.be = 4'hF;
      @(posedge clk); #1;
      bus.req = 1'b0;
      n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_wait got=%b exp=1", bus.busy); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_chk++; if ({bus.busy, bus.ready, bus.err} !== 3'b000 || bus.rdata !== 32'h0) begin
         n_fail++; $display("FAIL abort_outs got=%b%b%b/%h exp=000/0", bus.busy, bus.ready, bus.err, bus.rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      op(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, ge, gr, e);
      n_chk++; if (gr === 32'hDEADBEEF || gr !== e.rdata || ge !== 1'b0) begin
         n_fail++; $display("FAIL abort_reload got=%h/%b exp=%h/0", gr, ge, e.rdata);
      end
   endtask

   task automatic test_store_load();
      int lat; logic ge; logic [31:0] gr; exp_t e;
      op(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, lat, ge, gr, e);
      n_chk++; if (lat != 3) begin n_fail++; $display("FAIL store_latency got=%0d exp=3", lat); end
      n_chk++; if (ge !== e.err || gr !== e.rdata) begin
         n_fail++; $display("FAIL store_resp got=%b/%h exp=%b/%h", ge, gr, e.err, e.rdata);
      end
      op(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, lat, ge, gr, e);
      n_chk++; if (lat != 3) begin n_fail++; $display("FAIL load_latency got=%0d exp=3", lat); end
      n_chk++; if (ge !== e.err || gr !== e.rdata || gr !== 32'h12345678) begin
         n_fail++; $display("FAIL load_resp got=%b/%h exp=%b/%h", ge, gr, e.err, e.rdata);
      end
      @(posedge clk); #1;
      n_chk++; if (bus.ready !== 1'b0 || bus.rdata !== 32'h0) begin
         n_fail++; $display("FAIL load_pulse got=%b/%h exp=0/0", bus.ready, bus.rdata);
      end
   endtask

   task automatic test_byte_merge();
      int lat; logic ge; logic [31:0] gr; exp_t e;
      op(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF, lat, ge, gr, e);
      op(1'b0, 1'b1, 32'h8, 32'h00000011, 4'b0001, lat, ge, gr, e);
      n_chk++; if (ge !== e.err || gr !== e.rdata) begin
         n_fail++; $display("FAIL merge_store_resp got=%b/%h exp=%b/%h", ge, gr, e.err, e.rdata);
      end
      op(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, lat, ge, gr, e);
      n_chk++; if (lat != 3 || ge !== 1'b0) begin
         n_fail++; $display("FAIL noop_store got=lat%0d/%b exp=lat3/0", lat, ge);
      end
      op(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, lat, ge, gr, e);
      n_chk++; if (gr !== e.rdata || gr !== 32'hAABBCC11 || ge !== 1'b0) begin
         n_fail++; $display("FAIL merge_load got=%h/%b exp=aabbcc11/0", gr, ge);
      end
   endtask

   task automatic test_errors();
      int lat; logic ge; logic [31:0] gr; exp_t e;
      op(1'b0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, lat, ge, gr, e);
      op(1'b0, 1'b0, 32'h42, 32'h0, 4'h0, lat, ge, gr, e);
      n_chk++; if (ge !== 1'b1 || e.err !== 1'b1 || gr !== 32'h0 || lat != 3) begin
         n_fail++; $display("FAIL misaligned_load got=%b/%h lat%0d exp=1/0 lat3", ge, gr, lat);
      end
      @(posedge clk); #1;
      n_chk++; if (bus.err !== 1'b0 || bus.ready !== 1'b0) begin
         n_fail++; $display("FAIL err_pulse got=%b/%b exp=0/0", bus.err, bus.ready);
      end
      op(1'b0, 1'b1, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, lat, ge, gr, e);
      n_chk++; if (ge !== 1'b1 || e.err !== 1'b1 || gr !== 32'h0) begin
         n_fail++; $display("FAIL range_store got=%b/%h exp=1/0", ge, gr);
      end
      op(1'b0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, lat, ge, gr, e);
      n_chk++; if (ge !== e.err || ge !== 1'b1) begin
         n_fail++; $display("FAIL misaligned_store got=%b exp=1", ge);
      end
      op(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat, ge, gr, e);
      n_chk++; if (ge !== 1'b0 || gr !== e.rdata || gr !== 32'h55AA55AA) begin
         n_fail++; $display("FAIL word0_reload got=%b/%h exp=0/55aa55aa", ge, gr);
      end
   endtask

   // req held high: one acceptance every 4 cycles; addr is bad while busy so a
   // sneaked-in acceptance would surface as err.
   task automatic test_req_held();
      int pulses; int first; int prev; int k;
      pulses = 0; first = -1; prev = -1;
      k = 0;
      while (bus.busy && k < int'(TMO)) begin @(posedge clk); #1; k++; end
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h40; bus.wdata = 32'h0; bus.be = 4'h0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (bus.ready) begin
            pulses++;
            if (first < 0) first = c;
            n_chk++; if (bus.err !== 1'b0 || bus.rdata !== mdl[16]) begin
               n_fail++; $display("FAIL held_resp cyc%0d got=%b/%h exp=0/%h", c, bus.err, bus.rdata, mdl[16]);
            end
            if (prev >= 0) begin
               n_chk++; if (c - prev != 4) begin n_fail++; $display("FAIL held_gap got=%0d exp=4", c - prev); end
            end
            prev = c;
         end
         bus.addr = bus.busy ? 32'h41 : 32'h40;
      end
      bus.req = 1'b0;
      n_chk++; if (pulses != 3) begin n_fail++; $display("FAIL held_pulses got=%0d exp=3", pulses); end
      n_chk++; if (first != 3) begin n_fail++; $display("FAIL held_first got=%0d exp=3", first); end
   endtask

   task automatic test_zero_wait();
      int lat; logic ge; logic [31:0] gr; exp_t e;
      op(1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, ge, gr, e);
      n_chk++; if (lat != 1 || ge !== e.err) begin
         n_fail++; $display("FAIL zw_store got=lat%0d/%b exp=lat1/%b", lat, ge, e.err);
      end
      op(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, ge, gr, e);
      n_chk++; if (lat != 1) begin n_fail++; $display("FAIL zw_latency got=%0d exp=1", lat); end
      n_chk++; if (gr !== e.rdata || gr !== 32'hCAFEF00D || ge !== 1'b0) begin
         n_fail++; $display("FAIL zw_load got=%h/%b exp=cafef00d/0", gr, ge);
      end
      n_chk++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL zw_busy_on got=%b exp=1", bus0.busy); end
      @(posedge clk); #1;
      n_chk++; if (bus0.busy !== 1'b0 || bus0.ready !== 1'b0) begin
         n_fail++; $display("FAIL zw_busy_off got=%b/%b exp=0/0", bus0.busy, bus0.ready);
      end
   endtask

   initial begin
      bus.req  = 1'b0; bus.we  = 1'b0; bus.addr  = '0; bus.wdata  = '0; bus.be  = '0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0;
      rst = 1'b1; rst0 = 1'b1;
      test_reset();
      test_reset_abort();
      test_store_load();
      test_byte_merge();
      test_errors();
      test_req_held();
      test_zero_wait();
      n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
